// File: rtl/multiplier_seq_nbit.sv
// Iterative radix-2 shift-add N x N multiplier with a full 2N-bit product and
// a run-time unsigned/signed mode. The engine handles one operation at a time.
module multiplier_seq_nbit #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   mul
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [2*N-1:0]   mcand_reg, mcand_next;
    logic [N-1:0]     mplier_reg, mplier_next;
    logic [2*N-1:0]   acc_reg, acc_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             sign_reg, sign_next;
    logic [2*N-1:0]   mul_reg, mul_next;

    logic             a_neg, b_neg;
    logic [N-1:0]     a_mag, b_mag;
    logic [2*N-1:0]   addend;
    logic [2*N-1:0]   acc_sum;

    // Magnitudes are taken before the loop so the engine itself is purely unsigned.
    assign a_neg = signed_mode & a[N-1];
    assign b_neg = signed_mode & b[N-1];
    assign a_mag = a_neg ? (~a + N'(1)) : a;
    assign b_mag = b_neg ? (~b + N'(1)) : b;

    // Partial product: the shifted multiplicand gated by the current multiplier bit.
    generate
        for (genvar gi = 0; gi < 2 * N; gi++) begin : g_addend
            assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
        end
    endgenerate

    assign acc_sum = acc_reg + addend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            sign_reg   <= 1'b0;
            mul_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            acc_reg    <= acc_next;
            cnt_reg    <= cnt_next;
            sign_reg   <= sign_next;
            mul_reg    <= mul_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        acc_next    = acc_reg;
        cnt_next    = cnt_reg;
        sign_next   = sign_reg;
        mul_next    = mul_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    mcand_next  = {{N{1'b0}}, a_mag};
                    mplier_next = b_mag;
                    acc_next    = '0;
                    cnt_next    = '0;
                    sign_next   = signed_mode & (a[N-1] ^ b[N-1]);
                    state_next  = RUN;
                end
            end
            RUN: begin
                acc_next    = acc_sum;
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                cnt_next    = cnt_reg + CW'(1);
                if (cnt_reg == LAST_BIT) begin
                    // The final partial sum goes straight into the product register.
                    mul_next   = sign_reg ? (~acc_sum + (2 * N)'(1)) : acc_sum;
                    cnt_next   = '0;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign mul       = mul_reg;

endmodule

// File: tb/tb_multiplier_seq_nbit.sv
// Directed and random checks for multiplier_seq_nbit at N=8 and N=16:
// products, latency, backpressure, asynchronous reset and throughput spacing.
module tb_multiplier_seq_nbit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        iv8, ir8, m8, ov8, or8;
    logic [7:0]  a8, b8;
    logic [15:0] mul8;

    logic        iv16, ir16, m16, ov16, or16;
    logic [15:0] a16, b16;
    logic [31:0] mul16;

    int n_checks = 0;
    int n_errors = 0;

    multiplier_seq_nbit #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .signed_mode(m8),
        .out_valid(ov8), .out_ready(or8), .mul(mul8)
    );

    multiplier_seq_nbit #(.N(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .signed_mode(m16),
        .out_valid(ov16), .out_ready(or16), .mul(mul16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic m);
        longint sx, sy;
        sx = m ? longint'($signed(x)) : longint'(x);
        sy = m ? longint'($signed(y)) : longint'(y);
        return 16'(sx * sy);
    endfunction

    function automatic logic [31:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic m);
        longint sx, sy;
        sx = m ? longint'($signed(x)) : longint'(x);
        sy = m ? longint'($signed(y)) : longint'(y);
        return 32'(sx * sy);
    endfunction

    // One directed operation on the 8-bit unit; optionally leaves it parked in DONE.
    task automatic run8(input string tag, input logic [7:0] aa, input logic [7:0] bb,
                        input logic mm, input logic [15:0] exp, input bit hs);
        int cyc;
        int ready_seen;
        @(negedge clk);
        cyc = 0;
        while (!ir8 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!ir8) check({tag, "_ready"}, 32'(ir8), 32'd1);
        a8 = aa; b8 = bb; m8 = mm; iv8 = 1'b1; or8 = 1'b0;
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); m8 = 1'($urandom);
        cyc = 0;
        ready_seen = 0;
        while (!ov8 && cyc < 40) begin
            if (ir8) ready_seen++;
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'd8);
        check({tag, "_busy"}, 32'(ready_seen), 32'd0);
        check({tag, "_mul"}, 32'(mul8), 32'(exp));
        $display("%s: a=%h b=%h mode=%0d mul=%h exp=%h lat=%0d", tag, aa, bb, mm, mul8, exp, cyc);
        if (hs) begin
            or8 = 1'b1;
            @(posedge clk);
            #1;
            or8 = 1'b0;
            check({tag, "_idle"}, 32'({ov8, ir8}), 32'b01);
            check({tag, "_keep"}, 32'(mul8), 32'(exp));
        end
    endtask

    task automatic rand8();
        int acc_n = 0, prod_n = 0, cyc = 0, last_rise = -1, sp;
        logic ov_prev = 1'b0;
        logic [15:0] q[$];
        logic [15:0] e;
        while ((acc_n < 1000 || prod_n < 1000) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (ov8 && !ov_prev) begin
                if (last_rise >= 0) begin
                    sp = cyc - last_rise;
                    check("r8_spacing", 32'((sp >= 10) ? 10 : sp), 32'd10);
                end
                last_rise = cyc;
            end
            ov_prev = ov8;
            or8 = 1'($urandom_range(0, 1));
            if (acc_n < 1000) begin
                iv8 = ($urandom_range(0, 3) != 0);
                a8 = 8'($urandom); b8 = 8'($urandom); m8 = 1'($urandom);
            end else begin
                iv8 = 1'b0;
            end
            if (ov8 && or8) begin
                if (q.size() == 0) begin
                    check("r8_queue", 32'(q.size()), 32'd1);
                end else begin
                    e = q.pop_front();
                    check("r8_mul", 32'(mul8), 32'(e));
                    $display("r8 #%0d mul=%h exp=%h", prod_n, mul8, e);
                end
                prod_n++;
            end
            if (iv8 && ir8) begin
                q.push_back(ref8(a8, b8, m8));
                acc_n++;
            end
        end
        iv8 = 1'b0;
        or8 = 1'b0;
        check("r8_accepted", 32'(acc_n), 32'd1000);
        check("r8_produced", 32'(prod_n), 32'(acc_n));
    endtask

    task automatic rand16();
        int acc_n = 0, prod_n = 0, cyc = 0, last_rise = -1, sp;
        logic ov_prev = 1'b0;
        logic [31:0] q[$];
        logic [31:0] e;
        while ((acc_n < 1000 || prod_n < 1000) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (ov16 && !ov_prev) begin
                if (last_rise >= 0) begin
                    sp = cyc - last_rise;
                    check("r16_spacing", 32'((sp >= 18) ? 18 : sp), 32'd18);
                end
                last_rise = cyc;
            end
            ov_prev = ov16;
            or16 = 1'($urandom_range(0, 1));
            if (acc_n < 1000) begin
                iv16 = ($urandom_range(0, 3) != 0);
                a16 = 16'($urandom); b16 = 16'($urandom); m16 = 1'($urandom);
            end else begin
                iv16 = 1'b0;
            end
            if (ov16 && or16) begin
                if (q.size() == 0) begin
                    check("r16_queue", 32'(q.size()), 32'd1);
                end else begin
                    e = q.pop_front();
                    check("r16_mul", mul16, e);
                    $display("r16 #%0d mul=%h exp=%h", prod_n, mul16, e);
                end
                prod_n++;
            end
            if (iv16 && ir16) begin
                q.push_back(ref16(a16, b16, m16));
                acc_n++;
            end
        end
        iv16 = 1'b0;
        or16 = 1'b0;
        check("r16_accepted", 32'(acc_n), 32'd1000);
        check("r16_produced", 32'(prod_n), 32'(acc_n));
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0;
        iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; m8 = 1'b0;
        iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0; m16 = 1'b0;
        #1;
        check("rst_ready8", 32'(ir8), 32'd1);
        check("rst_valid8", 32'(ov8), 32'd0);
        check("rst_mul8", 32'(mul8), 32'd0);
        check("rst_ready16", 32'(ir16), 32'd1);
        check("rst_mul16", mul16, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run8("u_ff_ff",   8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1);
        run8("s_m3_x5",   8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b1);
        run8("u_253_x5",  8'hFD, 8'h05, 1'b0, 16'h04F1, 1'b1);
        run8("s_80_x80",  8'h80, 8'h80, 1'b1, 16'h4000, 1'b1);
        run8("s_80_x7f",  8'h80, 8'h7F, 1'b1, 16'hC080, 1'b1);
        run8("s_00_xff",  8'h00, 8'hFF, 1'b1, 16'h0000, 1'b1);
        run8("s_01_xff",  8'h01, 8'hFF, 1'b1, 16'hFFFF, 1'b1);

        // Backpressure: hold the result while new operands churn on the input.
        run8("bp_first",  8'h12, 8'h34, 1'b0, 16'h03A8, 1'b0);
        iv8 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); m8 = 1'($urandom);
            @(posedge clk);
            #1;
            check("bp_valid", 32'(ov8), 32'd1);
            check("bp_mul", 32'(mul8), 32'h03A8);
            check("bp_ready", 32'(ir8), 32'd0);
        end
        a8 = 8'h07; b8 = 8'h09; m8 = 1'b0; or8 = 1'b1;
        @(posedge clk);
        #1;
        or8 = 1'b0;
        check("bp_idle", 32'({ov8, ir8}), 32'b01);
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        check("bp_accept", 32'(ir8), 32'd0);
        cyc = 0;
        while (!ov8 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("bp_lat", 32'(cyc), 32'd8);
        check("bp_mul2", 32'(mul8), 32'h003F);
        $display("bp_pending: a=07 b=09 mode=0 mul=%h exp=003f lat=%0d", mul8, cyc);
        or8 = 1'b1;
        @(posedge clk);
        #1;
        or8 = 1'b0;

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h33; m8 = 1'b0; iv8 = 1'b1;
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_busy", 32'(ir8), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_valid", 32'(ov8), 32'd0);
        check("mid_mul", 32'(mul8), 32'd0);
        check("mid_ready", 32'(ir8), 32'd1);
        $display("mid_reset: ready=%0d valid=%0d mul=%h", ir8, ov8, mul8);
        @(negedge clk);
        rst_n = 1'b1;
        run8("rst_fresh", 8'h0C, 8'h0A, 1'b0, 16'h0078, 1'b1);

        fork
            rand8();
            rand16();
        join

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
